// File: rtl/omdc_row_fifo_if.sv
// ============================================================================
// Module : omdc_row_fifo_if
// Brief  : Control/data bundle between the OMDC controller and one row buffer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface omdc_row_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 11
);
    logic                  ROWFIFO_SetEn;
    logic                  ROWFIFO_OEn;
    logic                  ROWFIFO_Wptclr;
    logic                  ROWFIFO_Rptclr;
    logic [DATA_WIDTH-1:0] ROWFIFO_Data_In;
    logic [DATA_WIDTH-1:0] ROWFIFO_Data_Out;
    logic                  ROWFIFO_Data_Valid;
    logic                  ROWFIFO_Full;
    logic                  ROWFIFO_Empty;
    logic [ADDR_WIDTH:0]   ROWFIFO_Count;
    logic                  ROWFIFO_Overflow_Err;
    logic                  ROWFIFO_Underflow_Err;

    modport master (
        output ROWFIFO_SetEn, ROWFIFO_OEn, ROWFIFO_Wptclr, ROWFIFO_Rptclr, ROWFIFO_Data_In,
        input  ROWFIFO_Data_Out, ROWFIFO_Data_Valid, ROWFIFO_Full, ROWFIFO_Empty,
               ROWFIFO_Count, ROWFIFO_Overflow_Err, ROWFIFO_Underflow_Err
    );

    modport slave (
        input  ROWFIFO_SetEn, ROWFIFO_OEn, ROWFIFO_Wptclr, ROWFIFO_Rptclr, ROWFIFO_Data_In,
        output ROWFIFO_Data_Out, ROWFIFO_Data_Valid, ROWFIFO_Full, ROWFIFO_Empty,
               ROWFIFO_Count, ROWFIFO_Overflow_Err, ROWFIFO_Underflow_Err
    );
endinterface

`default_nettype wire

// File: rtl/omdc_row_fifo.sv
// ============================================================================
// Module : omdc_row_fifo
// Brief  : One-row line-store FIFO with pointer clears for row replay.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module omdc_row_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 11
) (
    input  wire logic         ROWFIFO_Clk,
    input  wire logic         ROWFIFO_Reset,
    omdc_row_fifo_if.slave    bus
);
    localparam int c_DEPTH = 1 << ADDR_WIDTH;
    localparam int c_PTR_W = ADDR_WIDTH + 1;
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

    logic [DATA_WIDTH-1:0] r_mem [0:c_DEPTH-1];
    logic [c_PTR_W-1:0]    r_wptr;
    logic [c_PTR_W-1:0]    r_rptr;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_data_valid;
    logic                  r_overflow_err;
    logic                  r_underflow_err;

    logic [c_PTR_W-1:0]    w_count;
    logic                  w_full;
    logic                  w_empty;
    logic [c_PTR_W-1:0]    w_wptr_post;
    logic [c_PTR_W-1:0]    w_rptr_post;
    logic                  w_rd_ok;
    logic                  w_wr_ok;
    logic                  w_flush;

    assign w_count = r_wptr - r_rptr;
    assign w_full  = w_count[ADDR_WIDTH];
    assign w_empty = (w_count == '0);

    // Clears take effect before the access in the same cycle
    assign w_wptr_post = bus.ROWFIFO_Wptclr ? '0 : r_wptr;
    assign w_rptr_post = bus.ROWFIFO_Rptclr ? '0 : r_rptr;

    assign w_rd_ok = bus.ROWFIFO_OEn &
                     (bus.ROWFIFO_Rptclr ? (w_wptr_post != '0) : !w_empty);
    // A full FIFO still accepts a write when a read frees a slot this cycle
    assign w_wr_ok = bus.ROWFIFO_SetEn &
                     (bus.ROWFIFO_Wptclr | !w_full | w_rd_ok);
    assign w_flush = bus.ROWFIFO_Wptclr & bus.ROWFIFO_Rptclr;

    always_ff @(posedge ROWFIFO_Clk) begin
        if (w_wr_ok) begin
            r_mem[w_wptr_post[ADDR_WIDTH-1:0]] <= bus.ROWFIFO_Data_In;
        end
    end

    always_ff @(posedge ROWFIFO_Clk or negedge ROWFIFO_Reset) begin
        if (!ROWFIFO_Reset) begin
            r_wptr          <= '0;
            r_rptr          <= '0;
            r_data_out      <= '0;
            r_data_valid    <= 1'b0;
            r_overflow_err  <= 1'b0;
            r_underflow_err <= 1'b0;
        end else begin
            r_wptr       <= w_wr_ok ? (w_wptr_post + c_PTR_ONE) : w_wptr_post;
            r_rptr       <= w_rd_ok ? (w_rptr_post + c_PTR_ONE) : w_rptr_post;
            r_data_valid <= w_rd_ok;
            if (w_rd_ok) begin
                r_data_out <= r_mem[w_rptr_post[ADDR_WIDTH-1:0]];
            end
            if (w_flush) begin
                r_overflow_err  <= 1'b0;
                r_underflow_err <= 1'b0;
            end else begin
                if (bus.ROWFIFO_SetEn && !w_wr_ok) r_overflow_err  <= 1'b1;
                if (bus.ROWFIFO_OEn && !w_rd_ok)   r_underflow_err <= 1'b1;
            end
        end
    end

    assign bus.ROWFIFO_Data_Out      = r_data_out;
    assign bus.ROWFIFO_Data_Valid    = r_data_valid;
    assign bus.ROWFIFO_Full          = w_full;
    assign bus.ROWFIFO_Empty         = w_empty;
    assign bus.ROWFIFO_Count         = w_count;
    assign bus.ROWFIFO_Overflow_Err  = r_overflow_err;
    assign bus.ROWFIFO_Underflow_Err = r_underflow_err;

endmodule

`default_nettype wire

// File: tb/tb_omdc_row_fifo.sv
// ============================================================================
// Module : tb_omdc_row_fifo
// Brief  : Self-checking bench for omdc_row_fifo against an integer row model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_omdc_row_fifo;
    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 1 << AW;

    logic tb_clk = 1'b0;
    logic rst_n  = 1'b0;
    always #5 tb_clk = ~tb_clk;

    omdc_row_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    omdc_row_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .ROWFIFO_Clk   (tb_clk),
        .ROWFIFO_Reset (rst_n),
        .bus           (bus)
    );

    // Reference: row contents plus absolute (never-wrapping) write/read positions
    logic [DW-1:0] m_row [DEPTH];
    int            m_w, m_r;
    logic          m_valid, m_ovf, m_unf;
    logic [DW-1:0] m_dout;

    int checks = 0;
    int passed = 0;

    function automatic logic [AW:0] m_count();
        return (AW+1)'(m_w - m_r);
    endfunction

    task automatic model_reset();
        m_w = 0; m_r = 0; m_valid = 1'b0; m_dout = '0; m_ovf = 1'b0; m_unf = 1'b0;
    endtask

    task automatic do_reset();
        bus.ROWFIFO_SetEn = 0; bus.ROWFIFO_OEn = 0;
        bus.ROWFIFO_Wptclr = 0; bus.ROWFIFO_Rptclr = 0; bus.ROWFIFO_Data_In = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge tb_clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    // Drive one clock cycle and advance the model by the same cycle
    task automatic cycle(input logic se, input logic oe, input logic wc,
                         input logic rc, input logic [DW-1:0] d);
        int  wpost, rpost;
        bit  full, empty, rd, wr;
        bus.ROWFIFO_SetEn = se; bus.ROWFIFO_OEn = oe;
        bus.ROWFIFO_Wptclr = wc; bus.ROWFIFO_Rptclr = rc; bus.ROWFIFO_Data_In = d;
        wpost = wc ? 0 : m_w;
        rpost = rc ? 0 : m_r;
        full  = (m_w - m_r) == DEPTH;
        empty = (m_w == m_r);
        rd    = oe && (rc ? (wpost != 0) : !empty);
        wr    = se && (wc || !full || rd);
        m_valid = rd;
        if (rd) m_dout = m_row[rpost % DEPTH];
        if (wr) m_row[wpost % DEPTH] = d;
        m_w = wpost + int'(wr);
        m_r = rpost + int'(rd);
        if (wc && rc) begin
            m_ovf = 1'b0; m_unf = 1'b0;
        end else begin
            if (se && !wr) m_ovf = 1'b1;
            if (oe && !rd) m_unf = 1'b1;
        end
        @(posedge tb_clk);
        #1;
        bus.ROWFIFO_SetEn = 0; bus.ROWFIFO_OEn = 0;
        bus.ROWFIFO_Wptclr = 0; bus.ROWFIFO_Rptclr = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.ROWFIFO_Empty !== 1'b1) $display("FAIL reset_empty got %b want 1", bus.ROWFIFO_Empty); else passed++;
        checks++; if (bus.ROWFIFO_Full !== 1'b0) $display("FAIL reset_full got %b want 0", bus.ROWFIFO_Full); else passed++;
        checks++; if (bus.ROWFIFO_Count !== 4'd0) $display("FAIL reset_count got %0d want 0", bus.ROWFIFO_Count); else passed++;
        checks++; if (bus.ROWFIFO_Data_Out !== 8'h00) $display("FAIL reset_dout got %h want 00", bus.ROWFIFO_Data_Out); else passed++;
        checks++; if (bus.ROWFIFO_Data_Valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.ROWFIFO_Data_Valid); else passed++;
        checks++; if ({bus.ROWFIFO_Overflow_Err, bus.ROWFIFO_Underflow_Err} !== 2'b00)
            $display("FAIL reset_errs got %b want 00", {bus.ROWFIFO_Overflow_Err, bus.ROWFIFO_Underflow_Err}); else passed++;
    endtask

    task automatic read_row(input string name);
        for (int i = 0; i < 8; i++) begin
            cycle(0, 1, 0, 0, '0);
            checks++; if (bus.ROWFIFO_Data_Valid !== 1'b1 || bus.ROWFIFO_Data_Out !== 8'(8'h10 + i))
                $display("FAIL %s_data[%0d] got v=%b d=%h want v=1 d=%h", name, i,
                         bus.ROWFIFO_Data_Valid, bus.ROWFIFO_Data_Out, 8'(8'h10 + i)); else passed++;
            checks++; if (bus.ROWFIFO_Count !== 4'(7 - i))
                $display("FAIL %s_count[%0d] got %0d want %0d", name, i, bus.ROWFIFO_Count, 7 - i); else passed++;
        end
    endtask

    task automatic test_write_read();
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1, 0, 0, 0, 8'(8'h10 + i));
        checks++; if (bus.ROWFIFO_Count !== 4'd8) $display("FAIL wr_count got %0d want 8", bus.ROWFIFO_Count); else passed++;
        read_row("rd");
        cycle(0, 0, 0, 0, '0);
        checks++; if (bus.ROWFIFO_Data_Valid !== 1'b0 || bus.ROWFIFO_Empty !== 1'b1)
            $display("FAIL rd_idle got v=%b e=%b want v=0 e=1", bus.ROWFIFO_Data_Valid, bus.ROWFIFO_Empty); else passed++;
        checks++; if ({bus.ROWFIFO_Overflow_Err, bus.ROWFIFO_Underflow_Err} !== 2'b00)
            $display("FAIL rd_errs got %b want 00", {bus.ROWFIFO_Overflow_Err, bus.ROWFIFO_Underflow_Err}); else passed++;
    endtask

    task automatic test_replay();
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1, 0, 0, 0, 8'(8'h10 + i));
        read_row("first");
        cycle(0, 0, 0, 1, '0);
        checks++; if (bus.ROWFIFO_Count !== 4'd8) $display("FAIL replay_count got %0d want 8", bus.ROWFIFO_Count); else passed++;
        read_row("replay");
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1, 0, 0, 0, 8'(8'h20 + i));
        checks++; if (bus.ROWFIFO_Full !== 1'b1) $display("FAIL full_flag got %b want 1", bus.ROWFIFO_Full); else passed++;
        cycle(1, 0, 0, 0, 8'h99);
        checks++; if (bus.ROWFIFO_Overflow_Err !== 1'b1 || bus.ROWFIFO_Count !== 4'd8)
            $display("FAIL full_drop got ovf=%b cnt=%0d want ovf=1 cnt=8", bus.ROWFIFO_Overflow_Err, bus.ROWFIFO_Count); else passed++;
        cycle(1, 1, 0, 0, 8'hAA);
        checks++; if (bus.ROWFIFO_Count !== 4'd8 || bus.ROWFIFO_Data_Valid !== 1'b1 || bus.ROWFIFO_Data_Out !== 8'h20)
            $display("FAIL full_rw got cnt=%0d v=%b d=%h want cnt=8 v=1 d=20",
                     bus.ROWFIFO_Count, bus.ROWFIFO_Data_Valid, bus.ROWFIFO_Data_Out); else passed++;
        cycle(0, 0, 1, 1, '0);
        checks++; if (bus.ROWFIFO_Count !== 4'd0 || bus.ROWFIFO_Empty !== 1'b1 ||
                      bus.ROWFIFO_Overflow_Err !== 1'b0 || bus.ROWFIFO_Underflow_Err !== 1'b0)
            $display("FAIL flush got cnt=%0d e=%b ovf=%b unf=%b want 0 1 0 0", bus.ROWFIFO_Count,
                     bus.ROWFIFO_Empty, bus.ROWFIFO_Overflow_Err, bus.ROWFIFO_Underflow_Err); else passed++;
    endtask

    task automatic test_underflow();
        do_reset();
        cycle(0, 1, 0, 0, '0);
        checks++; if (bus.ROWFIFO_Data_Valid !== 1'b0 || bus.ROWFIFO_Underflow_Err !== 1'b1)
            $display("FAIL unf_read got v=%b unf=%b want v=0 unf=1", bus.ROWFIFO_Data_Valid, bus.ROWFIFO_Underflow_Err); else passed++;
        cycle(1, 1, 0, 0, 8'h55);
        checks++; if (bus.ROWFIFO_Data_Valid !== 1'b0 || bus.ROWFIFO_Count !== 4'd1 || bus.ROWFIFO_Underflow_Err !== 1'b1)
            $display("FAIL unf_rw got v=%b cnt=%0d unf=%b want v=0 cnt=1 unf=1",
                     bus.ROWFIFO_Data_Valid, bus.ROWFIFO_Count, bus.ROWFIFO_Underflow_Err); else passed++;
        cycle(0, 1, 0, 0, '0);
        checks++; if (bus.ROWFIFO_Data_Valid !== 1'b1 || bus.ROWFIFO_Data_Out !== 8'h55)
            $display("FAIL unf_after got v=%b d=%h want v=1 d=55", bus.ROWFIFO_Data_Valid, bus.ROWFIFO_Data_Out); else passed++;
    endtask

    task automatic test_clear_access();
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 8'(8'h30 + i));
        cycle(1, 0, 1, 0, 8'h77);
        checks++; if (bus.ROWFIFO_Count !== 4'd1) $display("FAIL wclr_wr_count got %0d want 1", bus.ROWFIFO_Count); else passed++;
        cycle(0, 1, 0, 1, '0);
        checks++; if (bus.ROWFIFO_Data_Valid !== 1'b1 || bus.ROWFIFO_Data_Out !== 8'h77 || bus.ROWFIFO_Count !== 4'd0)
            $display("FAIL rclr_rd got v=%b d=%h cnt=%0d want v=1 d=77 cnt=0",
                     bus.ROWFIFO_Data_Valid, bus.ROWFIFO_Data_Out, bus.ROWFIFO_Count); else passed++;
    endtask

    task automatic test_random();
        logic [17:0] got, exp;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            cycle(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50),
                  1'b0, 1'($urandom_range(0, 99) < 3 && m_w <= DEPTH), 8'($urandom));
            got = {bus.ROWFIFO_Data_Valid, bus.ROWFIFO_Data_Out, bus.ROWFIFO_Count, bus.ROWFIFO_Full,
                   bus.ROWFIFO_Empty, bus.ROWFIFO_Overflow_Err, bus.ROWFIFO_Underflow_Err};
            exp = {m_valid, m_dout, m_count(), 1'(m_w - m_r == DEPTH), 1'(m_w == m_r), m_ovf, m_unf};
            checks++; if (got !== exp) $display("FAIL random[%0d] got %h want %h", n, got, exp); else passed++;
            // Periodically flush so the unbounded model positions stay aligned with small rows
            if (n % 50 == 49) cycle(0, 0, 1, 1, '0);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 8'(8'h40 + i));
        cycle(0, 1, 0, 0, '0);
        cycle(0, 1, 0, 0, '0);
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({bus.ROWFIFO_Count, bus.ROWFIFO_Empty, bus.ROWFIFO_Full, bus.ROWFIFO_Data_Valid,
                       bus.ROWFIFO_Data_Out, bus.ROWFIFO_Overflow_Err, bus.ROWFIFO_Underflow_Err} !== {4'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0})
            $display("FAIL async_reset got cnt=%0d e=%b f=%b v=%b d=%h", bus.ROWFIFO_Count, bus.ROWFIFO_Empty,
                     bus.ROWFIFO_Full, bus.ROWFIFO_Data_Valid, bus.ROWFIFO_Data_Out); else passed++;
        do_reset();
    endtask

    initial begin
        bus.ROWFIFO_SetEn = 0; bus.ROWFIFO_OEn = 0;
        bus.ROWFIFO_Wptclr = 0; bus.ROWFIFO_Rptclr = 0; bus.ROWFIFO_Data_In = '0;
        for (int i = 0; i < DEPTH; i++) m_row[i] = '0;
        model_reset();
        test_reset();
        test_write_read();
        test_replay();
        test_full();
        test_underflow();
        test_clear_access();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
